multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
Parametrised multicycle control unit for the MIPS-subset CPU. It sequences IF/ID/EX/MEM/WB with variable-latency instruction and data memory handshakes, a stall input, illegal-opcode and bus-timeout trapping, and a retired-instruction counter. The decoded control flags are latched at ID exit and held stable for the rest of the instruction. It sits between the instruction register and the datapath; the datapath consumes the flags and strobes.

Parameters:
OPCODE_W, 6, opcode field width
FUNCT_W, 6, funct field width
ALU_OP_W, 4, ALU operation code width
ICOUNT_W, 32, retired-instruction counter width
MEM_TIMEOUT, 15, wait cycles without ready before TRAP; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
opcode  in  OPCODE_W  instruction-register opcode, valid from ID
funct  in  FUNCT_W  instruction-register funct
stall  in  1  freeze FSM
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
state  out  3  current state encoding
state_pc / state_regfile_read / state_memory / state_regfile_write  out  1 each  state==IF / ID / MEM / WB
imem_req, dmem_req  out  1  memory request, held until ready
ir_write, pc_write, pc_write_cond  out  1  datapath strobes
reg_dst_flag, alu_src_flag, mem_to_reg_flag, reg_write_flag, mem_read_flag, mem_write_flag, branch_flag, jump_flag  out  1  latched flags
alu_op  out  ALU_OP_W  latched ALU operation
instr_retired  out  1  one-cycle pulse
icount  out  ICOUNT_W  retired count, wraps modulo 2^ICOUNT_W
illegal_op, bus_error  out  1  sticky trap causes

Behaviour:
- Reset (sync, rst=1 at the edge): state=IF; all flags, strobes, sticky bits and icount=0; timeout counter=0. Reset mid-instruction aborts it with no retire.
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=5. Outputs are Moore, decoded from registered state plus latched class.
- IF: imem_req=1. When imem_ready=1: ir_write=1, pc_write=1 (PC+4), next=ID.
- ID: decode. Illegal opcode, or R-type with unsupported funct: next=TRAP, illegal_op=1. Otherwise latch flags and alu_op, next=EX.
- EX, beq: pc_write_cond=1, retire, next=IF.
- EX, j: pc_write=1, retire, next=IF.
- EX, lw/sw: next=MEM.
- EX, R-type/addi/ori: next=WB.
- MEM: dmem_req=1. When dmem_ready=1: lw goes to WB; sw retires and goes to IF.
- WB: reg_write_flag effective this cycle only; retire, next=IF.
- TRAP: absorbing until rst; all reqs and strobes=0.
- Supported instructions: R-type 000000 with funct add 100000, sub 100010, and 100100, or 100101, slt 101010; lw 100011; sw 101011; beq 000100; j 000010; addi 001000; ori 001101.
- Latency with zero-wait memory (ready same cycle as req): beq/j=3, R/I/sw=4, lw=5 cycles.
- Retire: instr_retired pulses in the cycle leaving the final state; icount increments on the following edge.
- Stall=1: state, timeout counter and latched flags hold. ir_write, pc_write, pc_write_cond, instr_retired and reg_write_flag are forced 0. Reqs stay asserted. A ready arriving during stall is ignored; memory must hold ready until accepted.
- Timeout: the counter increments each non-stalled cycle with req=1 and ready=0, and clears on state change. When it reaches MEM_TIMEOUT: next=TRAP, bus_error=1. If ready=1 in that same cycle, ready wins.

Decomposition:
- Shared defines: state encodings and STATE_LEN; opcode/funct constants; ALU op codes; instruction-class encoding (RTYPE, ITYPE, LOAD, STORE, BRANCH, JUMP, ILLEGAL).
- Sub-module ctrl_decode: combinational opcode/funct to class, flags, alu_op and illegal.
- multicycle_ctrl_fsm holds the state register, flag latch, timeout counter and icount.

Test Plan:
- R-type add (000000/100000), both readys tied 1: IF→ID→EX→WB→IF in 4 cycles; reg_write_flag=1 and reg_dst_flag=1 in WB; icount 0→1.
- lw with dmem_ready delayed 3 cycles: dmem_req held 4 cycles in MEM; WB with mem_to_reg_flag=1; 8 cycles total.
- beq then j: pc_write_cond pulses in EX for beq, pc_write in EX for j; each takes 3 cycles; icount +2.
- Opcode 111111: TRAP after ID, illegal_op=1 and sticky; rst for 1 cycle returns to IF, illegal_op=0, icount=0.
- MEM_TIMEOUT=15 with imem_ready held 0: TRAP after 15 wait cycles, bus_error=1. Repeat with ready on cycle 15: proceeds to ID.
- stall=1 for 5 cycles during MEM of sw with dmem_ready=1: state stays MEM, no retire; after release, retire in the next cycle.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, instruction
// classes, opcode/funct constants, ALU operation codes and the control-flag bundle.
package multicycle_ctrl_fsm_pkg;

    localparam int STATE_LEN = 3;

    typedef enum logic [STATE_LEN-1:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_ITYPE   = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JUMP    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef struct packed {
        logic reg_dst;
        logic alu_src;
        logic mem_to_reg;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
    } ctrl_flags_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Datapath/memory-facing signal bundle of the control unit; the controller
// uses the master view, the datapath and memories use the slave view.
interface multicycle_ctrl_fsm_if #(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int ALU_OP_W = 4,
    parameter int ICOUNT_W = 32
);
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT_W-1:0]  funct;
    logic                stall;
    logic                imem_ready;
    logic                dmem_ready;

    logic [2:0]          state;
    logic                state_pc;
    logic                state_regfile_read;
    logic                state_memory;
    logic                state_regfile_write;
    logic                imem_req;
    logic                dmem_req;
    logic                ir_write;
    logic                pc_write;
    logic                pc_write_cond;
    logic                reg_dst_flag;
    logic                alu_src_flag;
    logic                mem_to_reg_flag;
    logic                reg_write_flag;
    logic                mem_read_flag;
    logic                mem_write_flag;
    logic                branch_flag;
    logic                jump_flag;
    logic [ALU_OP_W-1:0] alu_op;
    logic                instr_retired;
    logic [ICOUNT_W-1:0] icount;
    logic                illegal_op;
    logic                bus_error;

    modport master (
        input  opcode, funct, stall, imem_ready, dmem_ready,
        output state, state_pc, state_regfile_read, state_memory, state_regfile_write,
               imem_req, dmem_req, ir_write, pc_write, pc_write_cond,
               reg_dst_flag, alu_src_flag, mem_to_reg_flag, reg_write_flag,
               mem_read_flag, mem_write_flag, branch_flag, jump_flag, alu_op,
               instr_retired, icount, illegal_op, bus_error
    );

    modport slave (
        output opcode, funct, stall, imem_ready, dmem_ready,
        input  state, state_pc, state_regfile_read, state_memory, state_regfile_write,
               imem_req, dmem_req, ir_write, pc_write, pc_write_cond,
               reg_dst_flag, alu_src_flag, mem_to_reg_flag, reg_write_flag,
               mem_read_flag, mem_write_flag, branch_flag, jump_flag, alu_op,
               instr_retired, icount, illegal_op, bus_error
    );

endinterface

// File: rtl/multicycle_ctrl_fsm_ctrl_decode.sv
// Combinational instruction decoder: opcode/funct to instruction class,
// datapath control flags and ALU operation.
module ctrl_decode
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int ALU_OP_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    output instr_class_t        cls,
    output ctrl_flags_t         flags,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal
);

    always_comb begin
        cls    = CLS_ILLEGAL;
        flags  = '0;
        alu_op = '0;
        case (opcode)
            OPCODE_W'(OP_RTYPE): begin
                cls             = CLS_RTYPE;
                flags.reg_dst   = 1'b1;
                flags.reg_write = 1'b1;
                case (funct)
                    FUNCT_W'(FN_ADD): alu_op = ALU_OP_W'(ALU_ADD);
                    FUNCT_W'(FN_SUB): alu_op = ALU_OP_W'(ALU_SUB);
                    FUNCT_W'(FN_AND): alu_op = ALU_OP_W'(ALU_AND);
                    FUNCT_W'(FN_OR):  alu_op = ALU_OP_W'(ALU_OR);
                    FUNCT_W'(FN_SLT): alu_op = ALU_OP_W'(ALU_SLT);
                    default: begin
                        cls   = CLS_ILLEGAL;
                        flags = '0;
                    end
                endcase
            end
            OPCODE_W'(OP_LW): begin
                cls              = CLS_LOAD;
                flags.alu_src    = 1'b1;
                flags.mem_to_reg = 1'b1;
                flags.reg_write  = 1'b1;
                flags.mem_read   = 1'b1;
                alu_op           = ALU_OP_W'(ALU_ADD);
            end
            OPCODE_W'(OP_SW): begin
                cls             = CLS_STORE;
                flags.alu_src   = 1'b1;
                flags.mem_write = 1'b1;
                alu_op          = ALU_OP_W'(ALU_ADD);
            end
            OPCODE_W'(OP_BEQ): begin
                cls          = CLS_BRANCH;
                flags.branch = 1'b1;
                alu_op       = ALU_OP_W'(ALU_SUB);
            end
            OPCODE_W'(OP_J): begin
                cls        = CLS_JUMP;
                flags.jump = 1'b1;
            end
            OPCODE_W'(OP_ADDI): begin
                cls             = CLS_ITYPE;
                flags.alu_src   = 1'b1;
                flags.reg_write = 1'b1;
                alu_op          = ALU_OP_W'(ALU_ADD);
            end
            OPCODE_W'(OP_ORI): begin
                cls             = CLS_ITYPE;
                flags.alu_src   = 1'b1;
                flags.reg_write = 1'b1;
                alu_op          = ALU_OP_W'(ALU_OR);
            end
            default: ;
        endcase
    end

    assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle IF/ID/EX/MEM/WB sequencer with memory handshakes, stall, illegal-op
// and bus-timeout trapping, latched control flags and a retired-instruction count.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int          OPCODE_W    = 6,
    parameter int          FUNCT_W     = 6,
    parameter int          ALU_OP_W    = 4,
    parameter int          ICOUNT_W    = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_ctrl_fsm_if.master bus
);

    localparam int               TO_W      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(MEM_TIMEOUT);
    localparam logic             TO_ENABLE = (MEM_TIMEOUT != 0);

    state_t              state_q, state_d;
    instr_class_t        cls_q, cls_d;
    ctrl_flags_t         flags_q, flags_d;
    logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [ICOUNT_W-1:0] icount_q, icount_d;
    logic                illegal_q, illegal_d;
    logic                bus_err_q, bus_err_d;

    instr_class_t        dec_cls;
    ctrl_flags_t         dec_flags;
    logic [ALU_OP_W-1:0] dec_alu_op;
    logic                dec_illegal;

    logic adv, ready_sel;
    logic imem_req, dmem_req, ir_write, pc_write, pc_write_cond, retire;

    ctrl_decode #(
        .OPCODE_W (OPCODE_W),
        .FUNCT_W  (FUNCT_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_decode (
        .opcode  (bus.opcode),
        .funct   (bus.funct),
        .cls     (dec_cls),
        .flags   (dec_flags),
        .alu_op  (dec_alu_op),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        flags_d       = flags_q;
        alu_op_d      = alu_op_q;
        to_d          = to_q;
        icount_d      = icount_q;
        illegal_d     = illegal_q;
        bus_err_d     = bus_err_q;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        retire        = 1'b0;
        ready_sel     = 1'b0;
        // Strobes and transitions only fire on a live, non-reset cycle.
        adv           = !bus.stall && !rst;

        case (state_q)
            S_IF: begin
                imem_req  = 1'b1;
                ready_sel = bus.imem_ready;
                if (adv && ready_sel) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_ID;
                end
            end
            S_ID: begin
                if (adv) begin
                    if (dec_illegal) begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end else begin
                        cls_d    = dec_cls;
                        flags_d  = dec_flags;
                        alu_op_d = dec_alu_op;
                        state_d  = S_EX;
                    end
                end
            end
            S_EX: begin
                if (adv) begin
                    case (cls_q)
                        CLS_BRANCH: begin
                            pc_write_cond = 1'b1;
                            retire        = 1'b1;
                            state_d       = S_IF;
                        end
                        CLS_JUMP: begin
                            pc_write = 1'b1;
                            retire   = 1'b1;
                            state_d  = S_IF;
                        end
                        CLS_LOAD, CLS_STORE: state_d = S_MEM;
                        default:             state_d = S_WB;
                    endcase
                end
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                ready_sel = bus.dmem_ready;
                if (adv && ready_sel) begin
                    if (cls_q == CLS_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_IF;
                    end
                end
            end
            S_WB: begin
                if (adv) begin
                    retire  = 1'b1;
                    state_d = S_IF;
                end
            end
            S_TRAP: ;
            default: state_d = S_TRAP;
        endcase

        // Timeout fires only on a wait cycle, so a ready in the limit cycle wins.
        if (TO_ENABLE && adv && (imem_req || dmem_req) && !ready_sel) begin
            if (to_q == TO_LIMIT) begin
                state_d   = S_TRAP;
                bus_err_d = 1'b1;
            end else begin
                to_d = to_q + TO_W'(1);
            end
        end
        if (state_d != state_q) begin
            to_d = '0;
        end

        if (retire) begin
            icount_d = icount_q + ICOUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IF;
            cls_q     <= CLS_RTYPE;
            flags_q   <= '0;
            alu_op_q  <= '0;
            to_q      <= '0;
            icount_q  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            flags_q   <= flags_d;
            alu_op_q  <= alu_op_d;
            to_q      <= to_d;
            icount_q  <= icount_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus.state               = state_q;
    assign bus.state_pc            = (state_q == S_IF);
    assign bus.state_regfile_read  = (state_q == S_ID);
    assign bus.state_memory        = (state_q == S_MEM);
    assign bus.state_regfile_write = (state_q == S_WB);
    assign bus.imem_req            = imem_req;
    assign bus.dmem_req            = dmem_req;
    assign bus.ir_write            = ir_write;
    assign bus.pc_write            = pc_write;
    assign bus.pc_write_cond       = pc_write_cond;
    assign bus.reg_dst_flag        = flags_q.reg_dst;
    assign bus.alu_src_flag        = flags_q.alu_src;
    assign bus.mem_to_reg_flag     = flags_q.mem_to_reg;
    assign bus.reg_write_flag      = flags_q.reg_write && (state_q == S_WB) && adv;
    assign bus.mem_read_flag       = flags_q.mem_read;
    assign bus.mem_write_flag      = flags_q.mem_write;
    assign bus.branch_flag         = flags_q.branch;
    assign bus.jump_flag           = flags_q.jump;
    assign bus.alu_op              = alu_op_q;
    assign bus.instr_retired       = retire;
    assign bus.icount              = icount_q;
    assign bus.illegal_op          = illegal_q;
    assign bus.bus_error           = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: table-driven instructions with a
// retire-time scoreboard, plus hand-written trap, timeout and reset sequences.
module tb_multicycle_ctrl_fsm;

    localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EX = 3'd2;
    localparam logic [2:0] ST_MEM = 3'd3, ST_WB = 3'd4, ST_TRAP = 3'd5;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         iw;
        int         dw;
        int         st;
        logic [7:0] flags;
        logic [3:0] alu;
        int         lat;
        int         mc;
        int         pcw;
        int         pcc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    vec_t tbl[$];
    vec_t sb_q[$];
    vec_t cur;
    int   lat = 0, mc = 0, pcw = 0, pcc = 0;
    logic [31:0] model_icount = '0;

    multicycle_ctrl_fsm_if #(.OPCODE_W(6), .FUNCT_W(6), .ALU_OP_W(4), .ICOUNT_W(32)) bus ();

    multicycle_ctrl_fsm #(
        .OPCODE_W(6), .FUNCT_W(6), .ALU_OP_W(4), .ICOUNT_W(32), .MEM_TIMEOUT(15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_flags();
        return {bus.reg_dst_flag, bus.alu_src_flag, bus.mem_to_reg_flag, bus.reg_write_flag,
                bus.mem_read_flag, bus.mem_write_flag, bus.branch_flag, bus.jump_flag};
    endfunction

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input int iw,
                                input int dw, input int st, input logic [7:0] fl,
                                input logic [3:0] alu, input int lt, input int m,
                                input int pw, input int pc);
        vec_t v;
        v.op = op; v.fn = fn; v.iw = iw; v.dw = dw; v.st = st; v.flags = fl;
        v.alu = alu; v.lat = lt; v.mc = m; v.pcw = pw; v.pcc = pc;
        return v;
    endfunction

    // Monitor: per-instruction activity counters, checked against the scoreboard at retire.
    always @(negedge clk) begin
        if (rst) begin
            lat = 0; mc = 0; pcw = 0; pcc = 0;
            model_icount = '0;
        end else begin
            lat++;
            if (bus.dmem_req)      mc++;
            if (bus.pc_write)      pcw++;
            if (bus.pc_write_cond) pcc++;
            chk("reg_write_only_in_wb", bus.reg_write_flag, (bus.state == ST_WB) && !bus.stall);
            if (bus.instr_retired) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    cur = sb_q.pop_front();
                    chk("retire_flags", dut_flags(), cur.flags);
                    chk("retire_alu_op", bus.alu_op, cur.alu);
                    chk("latency", lat, cur.lat);
                    chk("dmem_req_cycles", mc, cur.mc);
                    chk("pc_write_pulses", pcw, cur.pcw);
                    chk("pc_write_cond_pulses", pcc, cur.pcc);
                    chk("icount_at_retire", bus.icount, model_icount);
                end
                model_icount++;
                lat = 0; mc = 0; pcw = 0; pcc = 0;
            end
        end
    end

    task automatic do_reset(input int n);
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.stall      = 1'b0;
        rst            = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Starts and ends just after a rising edge, in the instruction's first IF cycle.
    task automatic run_instr(input vec_t v);
        int  iw = v.iw;
        int  dw = v.dw;
        int  st = v.st;
        bit  done = 1'b0;
        sb_q.push_back(v);
        bus.opcode = v.op;
        bus.funct  = v.fn;
        for (int c = 0; c < 100 && !done; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            bus.imem_ready = 1'b0;
            bus.dmem_ready = 1'b0;
            bus.stall      = 1'b0;
            if (bus.state == ST_IF) begin
                bus.imem_ready = (iw == 0);
                if (iw > 0) iw--;
            end else if (bus.state == ST_MEM) begin
                if (st > 0) begin
                    bus.stall      = 1'b1;
                    bus.dmem_ready = 1'b1;
                    st--;
                end else begin
                    bus.dmem_ready = (dw == 0);
                    if (dw > 0) dw--;
                end
            end
            @(negedge clk);
            if (bus.stall) begin
                chk("stall_no_retire", bus.instr_retired, 0);
                chk("stall_dmem_req_held", bus.dmem_req, 1);
            end
            done = bus.instr_retired;
        end
        if (!done) chk("retire_within_budget", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.opcode = '0; bus.funct = '0;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.stall = 1'b0;

        //          op         fn         iw dw st flags        alu   lat mc pcw pcc
        tbl.push_back(mk(6'b000000, 6'b100000, 0, 0, 0, 8'b10010000, 4'h2, 4, 0, 1, 0)); // add
        tbl.push_back(mk(6'b000000, 6'b100010, 0, 0, 0, 8'b10010000, 4'h6, 4, 0, 1, 0)); // sub
        tbl.push_back(mk(6'b000000, 6'b100100, 0, 0, 0, 8'b10010000, 4'h0, 4, 0, 1, 0)); // and
        tbl.push_back(mk(6'b000000, 6'b100101, 0, 0, 0, 8'b10010000, 4'h1, 4, 0, 1, 0)); // or
        tbl.push_back(mk(6'b000000, 6'b101010, 0, 0, 0, 8'b10010000, 4'h7, 4, 0, 1, 0)); // slt
        tbl.push_back(mk(6'b100011, 6'b000000, 0, 0, 0, 8'b01111000, 4'h2, 5, 1, 1, 0)); // lw
        tbl.push_back(mk(6'b100011, 6'b000000, 0, 3, 0, 8'b01111000, 4'h2, 8, 4, 1, 0)); // lw, dmem +3
        tbl.push_back(mk(6'b101011, 6'b000000, 0, 0, 0, 8'b01000100, 4'h2, 4, 1, 1, 0)); // sw
        tbl.push_back(mk(6'b000100, 6'b111111, 0, 0, 0, 8'b00000010, 4'h6, 3, 0, 1, 1)); // beq
        tbl.push_back(mk(6'b000010, 6'b000000, 0, 0, 0, 8'b00000001, 4'h0, 3, 0, 2, 0)); // j
        tbl.push_back(mk(6'b001000, 6'b000000, 0, 0, 0, 8'b01010000, 4'h2, 4, 0, 1, 0)); // addi
        tbl.push_back(mk(6'b001101, 6'b000000, 0, 0, 0, 8'b01010000, 4'h1, 4, 0, 1, 0)); // ori
        tbl.push_back(mk(6'b000000, 6'b100000, 2, 0, 0, 8'b10010000, 4'h2, 6, 0, 1, 0)); // add, imem +2
        tbl.push_back(mk(6'b101011, 6'b000000, 0, 0, 5, 8'b01000100, 4'h2, 9, 6, 1, 0)); // sw, 5 stalls

        do_reset(2);
        chk("reset_state", bus.state, ST_IF);
        chk("reset_state_pc", bus.state_pc, 1);
        chk("reset_icount", bus.icount, 0);
        chk("reset_flags", dut_flags(), 0);
        chk("reset_alu_op", bus.alu_op, 0);
        chk("reset_sticky", {bus.illegal_op, bus.bus_error}, 0);
        chk("reset_imem_req", bus.imem_req, 1);
        chk("reset_ir_write", bus.ir_write, 0);

        foreach (tbl[i]) run_instr(tbl[i]);

        // imem ready arrives exactly in the timeout-limit cycle: instruction proceeds.
        run_instr(mk(6'b000000, 6'b100000, 15, 0, 0, 8'b10010000, 4'h2, 19, 0, 1, 0));
        chk("late_ready_no_bus_error", bus.bus_error, 0);
        chk("icount_after_table", bus.icount, 15);

        // Reset during EX of a beq aborts it without a retire.
        bus.opcode = 6'b000100; bus.funct = '0; bus.imem_ready = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_id", bus.state, ST_ID);
        @(posedge clk); #1;
        chk("abort_in_ex", bus.state, ST_EX);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_no_retire", bus.instr_retired, 0);
        do_reset(1);
        chk("abort_icount_cleared", bus.icount, 0);
        chk("abort_state_if", bus.state, ST_IF);

        // imem never ready: trap after the wait budget expires.
        bus.opcode = 6'b000000; bus.funct = 6'b100000; bus.imem_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.state != ST_IF) break;
            n++;
        end
        chk("timeout_if_cycles", n, 16);
        chk("timeout_trap_state", bus.state, ST_TRAP);
        chk("timeout_bus_error", bus.bus_error, 1);
        chk("timeout_no_illegal", bus.illegal_op, 0);
        @(posedge clk); #1;
        do_reset(1);
        chk("timeout_reset_bus_error", bus.bus_error, 0);

        // Illegal opcode: trap after ID, sticky until reset.
        bus.opcode = 6'b111111; bus.funct = '0; bus.imem_ready = 1'b1;
        @(posedge clk); #1;
        chk("illegal_in_id", bus.state, ST_ID);
        @(posedge clk); #1;
        chk("illegal_trap_state", bus.state, ST_TRAP);
        chk("illegal_op_set", bus.illegal_op, 1);
        chk("illegal_reqs_off", {bus.imem_req, bus.dmem_req, bus.ir_write, bus.pc_write}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("illegal_trap_absorbing", bus.state, ST_TRAP);
        chk("illegal_op_sticky", bus.illegal_op, 1);
        do_reset(1);
        chk("illegal_reset_state", bus.state, ST_IF);
        chk("illegal_reset_flag", bus.illegal_op, 0);
        chk("illegal_reset_icount", bus.icount, 0);

        // R-type with an unsupported funct is also illegal.
        bus.opcode = 6'b000000; bus.funct = 6'b000001; bus.imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("bad_funct_trap", bus.state, ST_TRAP);
        chk("bad_funct_illegal", bus.illegal_op, 1);
        do_reset(1);

        run_instr(tbl[0]);
        chk("post_trap_icount", bus.icount, 1);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
